// File: rtl/acc_shift_reg_if.sv
// Handshake bundle for acc_shift_reg: operation request in, register state and status out.
interface acc_shift_reg_if #(
   parameter int N     = 8,
   parameter int AMT_W = 4
) ();
   logic             en;
   logic [2:0]       op;
   logic [N-1:0]     in;
   logic             sin;
   logic [AMT_W-1:0] amt;
   logic [N-1:0]     out;
   logic             cy;
   logic             zero;
   logic             busy;
   logic             done;

   modport master (
      output en, op, in, sin, amt,
      input  out, cy, zero, busy, done
   );

   modport slave (
      input  en, op, in, sin, amt,
      output out, cy, zero, busy, done
   );
endinterface

// File: rtl/acc_shift_reg.sv
// Accumulator / shift register: single-cycle load, clear, inc and dec, plus
// multi-cycle shl/shr/rol that step one bit per clock until amt steps are done.
module acc_shift_reg #(
   parameter int N     = 8,
   parameter int AMT_W = 4,
   parameter int ARITH = 0
) (
   input  logic          clk,
   input  logic          rst,
   acc_shift_reg_if.slave bus
);
   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_CLR  = 3'b010;
   localparam logic [2:0] OP_INC  = 3'b011;
   localparam logic [2:0] OP_DEC  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_SHR  = 3'b110;
   localparam logic [2:0] OP_ROL  = 3'b111;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           r_state, w_state_nxt;
   logic [N-1:0]     r_out, w_out_nxt;
   logic             r_cy, w_cy_nxt;
   logic             r_done, w_done_nxt;
   logic [AMT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_op, w_op_nxt;
   logic [N:0]       w_step_acc;
   logic [N:0]       w_step_run;

   // One shift step; result is {carry, new value}.
   function automatic logic [N:0] shift_step(input logic [2:0] f_op,
                                             input logic [N-1:0] v,
                                             input logic s);
      logic [N:0] r;
      r = {1'b0, v};
      case (f_op)
         OP_SHL:  r = {v[N-1], v[N-2:0], s};
         OP_SHR:  r = {v[0], ((ARITH != 0) ? v[N-1] : s), v[N-1:1]};
         OP_ROL:  r = {v[N-1], v[N-2:0], v[N-1]};
         default: r = {1'b0, v};
      endcase
      return r;
   endfunction

   assign w_step_acc = shift_step(bus.op, r_out, bus.sin);
   assign w_step_run = shift_step(r_op, r_out, bus.sin);

   always_comb begin
      w_state_nxt = r_state;
      w_out_nxt   = r_out;
      w_cy_nxt    = r_cy;
      w_done_nxt  = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_op_nxt    = r_op;
      case (r_state)
         IDLE: begin
            if (bus.en) begin
               case (bus.op)
                  OP_HOLD: ;
                  OP_LOAD: begin
                     w_out_nxt  = bus.in;
                     w_cy_nxt   = 1'b0;
                     w_done_nxt = 1'b1;
                  end
                  OP_CLR: begin
                     w_out_nxt  = '0;
                     w_cy_nxt   = 1'b0;
                     w_done_nxt = 1'b1;
                  end
                  OP_INC: begin
                     {w_cy_nxt, w_out_nxt} = {1'b0, r_out} + (N+1)'(1);
                     w_done_nxt = 1'b1;
                  end
                  OP_DEC: begin
                     // Borrow lands in the extra top bit only when r_out was zero.
                     {w_cy_nxt, w_out_nxt} = {1'b0, r_out} - (N+1)'(1);
                     w_done_nxt = 1'b1;
                  end
                  default: begin
                     w_op_nxt = bus.op;
                     if (bus.amt == '0) begin
                        w_done_nxt = 1'b1;
                     end else begin
                        {w_cy_nxt, w_out_nxt} = w_step_acc;
                        if (bus.amt == AMT_W'(1)) begin
                           w_done_nxt = 1'b1;
                        end else begin
                           w_cnt_nxt   = bus.amt - AMT_W'(1);
                           w_state_nxt = SHIFT;
                        end
                     end
                  end
               endcase
            end
         end
         SHIFT: begin
            {w_cy_nxt, w_out_nxt} = w_step_run;
            w_cnt_nxt = r_cnt - AMT_W'(1);
            if (r_cnt == AMT_W'(1)) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_out   <= '0;
         r_cy    <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         r_op    <= OP_HOLD;
      end else begin
         r_state <= w_state_nxt;
         r_out   <= w_out_nxt;
         r_cy    <= w_cy_nxt;
         r_done  <= w_done_nxt;
         r_cnt   <= w_cnt_nxt;
         r_op    <= w_op_nxt;
      end
   end

   assign bus.out  = r_out;
   assign bus.cy   = r_cy;
   assign bus.zero = (r_out == '0);
   assign bus.busy = (r_state == SHIFT);
   assign bus.done = r_done;
endmodule

// File: tb/tb_acc_shift_reg.sv
// Drives an ARITH=0 and an ARITH=1 instance with identical stimulus and checks
// both against a whole-operation arithmetic model.
module tb_acc_shift_reg;
   localparam int N = 8;
   localparam int AMT_W = 4;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   logic [N-1:0] m_out [2];
   logic         m_cy  [2];

   acc_shift_reg_if #(.N(N), .AMT_W(AMT_W)) u0 ();
   acc_shift_reg_if #(.N(N), .AMT_W(AMT_W)) u1 ();

   acc_shift_reg #(.N(N), .AMT_W(AMT_W), .ARITH(0)) dut0 (.clk(clk), .rst(rst), .bus(u0));
   acc_shift_reg #(.N(N), .AMT_W(AMT_W), .ARITH(1)) dut1 (.clk(clk), .rst(rst), .bus(u1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [2:0] o, input logic [7:0] d,
                        input logic s, input logic [3:0] a);
      u0.en = e; u0.op = o; u0.in = d; u0.sin = s; u0.amt = a;
      u1.en = e; u1.op = o; u1.in = d; u1.sin = s; u1.amt = a;
   endtask

   // Result of a whole op applied to v, computed in closed form.
   task automatic model_op(input int arith, input logic [2:0] o, input logic [7:0] d,
                           input logic s, input int k,
                           inout logic [7:0] v, inout logic c);
      longint unsigned x, mask, res;
      logic fill;
      mask = 64'hFF;
      x = v;
      case (o)
         3'd1: begin v = d; c = 1'b0; end
         3'd2: begin v = 8'h00; c = 1'b0; end
         3'd3: begin c = (v == 8'hFF); v = 8'(x + 1); end
         3'd4: begin c = (v == 8'h00); v = 8'(x - 1); end
         3'd5: if (k > 0) begin
            res = (x << k) | (s ? ((64'd1 << k) - 1) : 64'd0);
            c = (k <= N) ? v[N-k] : s;
            v = 8'(res & mask);
         end
         3'd6: if (k > 0) begin
            fill = (arith != 0) ? v[N-1] : s;
            res = (x >> k) | (fill ? (mask & ~(mask >> k)) : 64'd0);
            c = (k <= N) ? v[k-1] : fill;
            v = 8'(res & mask);
         end
         3'd7: if (k > 0) begin
            res = ((x << (k % N)) | (x >> (N - (k % N)))) & mask;
            v = 8'(res);
            c = v[0];
         end
         default: ;
      endcase
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_out0"}, u0.out, m_out[0]);
      chk({tag, "_cy0"}, u0.cy, m_cy[0]);
      chk({tag, "_zero0"}, u0.zero, (m_out[0] == 8'h00));
      chk({tag, "_out1"}, u1.out, m_out[1]);
      chk({tag, "_cy1"}, u1.cy, m_cy[1]);
      chk({tag, "_zero1"}, u1.zero, (m_out[1] == 8'h00));
   endtask

   task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] d,
                        input logic s, input logic [3:0] a, input bit junk);
      int b0, b1, guard, exp_busy;
      exp_busy = (o >= 3'd5 && a > 1) ? int'(a) - 1 : 0;
      @(negedge clk);
      drive(1'b1, o, d, s, a);
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_op(i, o, d, s, int'(a), m_out[i], m_cy[i]);
      @(negedge clk);
      if (junk) drive(1'b1, 3'd1, 8'hFF, s, a);
      else      drive(1'b0, 3'd0, 8'h00, s, a);
      b0 = 0; b1 = 0; guard = 0;
      while ((u0.busy || u1.busy) && guard < 40) begin
         if (u0.busy) b0++;
         if (u1.busy) b1++;
         if (u0.done || u1.done) chk({tag, "_done_in_busy"}, {u1.done, u0.done}, 0);
         guard++;
         @(negedge clk);
      end
      if (guard >= 40) chk({tag, "_timeout"}, guard, 0);
      drive(1'b0, 3'd0, 8'h00, s, a);
      chk({tag, "_busy0"}, b0, exp_busy);
      chk({tag, "_busy1"}, b1, exp_busy);
      chk({tag, "_done0"}, u0.done, (o != 3'd0));
      chk({tag, "_done1"}, u1.done, (o != 3'd0));
      check_state(tag);
      @(negedge clk);
      chk({tag, "_done_off"}, {u1.done, u0.done}, 0);
   endtask

   task automatic do_idle(input string tag, input logic [2:0] o, input logic [7:0] d);
      @(negedge clk);
      drive(1'b0, o, d, 1'b1, 4'd3);
      @(negedge clk);
      chk({tag, "_done"}, {u1.done, u0.done}, 0);
      check_state(tag);
   endtask

   initial begin
      logic [2:0] ro;
      logic [7:0] rd;
      rst = 1'b1;
      drive(1'b0, 3'd0, 8'h00, 1'b0, 4'd0);
      for (int i = 0; i < 2; i++) begin m_out[i] = 8'h00; m_cy[i] = 1'b0; end
      repeat (2) @(negedge clk);
      check_state("reset");
      chk("reset_busy", {u1.busy, u0.busy}, 0);
      chk("reset_done", {u1.done, u0.done}, 0);
      rst = 1'b0;

      // load + 3-bit shift left
      do_op("ld_a5", 3'd1, 8'hA5, 1'b0, 4'd0, 1'b0);
      do_op("shl3", 3'd5, 8'h00, 1'b0, 4'd3, 1'b0);
      chk("shl3_const_out", u0.out, 8'h28);
      chk("shl3_const_cy", u0.cy, 1);

      // wrap on inc / dec
      do_op("ld_ff", 3'd1, 8'hFF, 1'b0, 4'd0, 1'b0);
      do_op("inc_wrap", 3'd3, 8'h00, 1'b0, 4'd0, 1'b0);
      chk("inc_const", {u0.zero, u0.cy, u0.out}, {1'b1, 1'b1, 8'h00});
      do_op("dec_wrap", 3'd4, 8'h00, 1'b0, 4'd0, 1'b0);
      chk("dec_const", {u0.zero, u0.cy, u0.out}, {1'b0, 1'b1, 8'hFF});

      // shr fill: instance 0 sin-fill, instance 1 arithmetic
      do_op("ld_80", 3'd1, 8'h80, 1'b0, 4'd0, 1'b0);
      do_op("shr2", 3'd6, 8'h00, 1'b0, 4'd2, 1'b0);
      chk("shr2_logic", {u0.cy, u0.out}, {1'b0, 8'h20});
      chk("shr2_arith", {u1.cy, u1.out}, {1'b0, 8'hE0});

      // full rotation with a load request held during busy
      do_op("ld_5a", 3'd1, 8'h5A, 1'b0, 4'd0, 1'b0);
      do_op("rol8", 3'd7, 8'hFF, 1'b0, 4'd8, 1'b1);
      chk("rol8_const", u0.out, 8'h5A);

      do_op("shl0", 3'd5, 8'h00, 1'b1, 4'd0, 1'b0);
      chk("shl0_const", u0.out, 8'h5A);
      do_op("hold", 3'd0, 8'h33, 1'b0, 4'd2, 1'b0);

      // async reset in the middle of a rol amt=5
      @(negedge clk);
      drive(1'b1, 3'd7, 8'h00, 1'b0, 4'd5);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 3'd0, 8'h00, 1'b0, 4'd5);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin m_out[i] = 8'h00; m_cy[i] = 1'b0; end
      check_state("rst_mid");
      chk("rst_mid_busy", {u1.busy, u0.busy}, 0);
      chk("rst_mid_done", {u1.done, u0.done}, 0);
      #7 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("post_rst_quiet", {u1.busy, u1.done, u0.busy, u0.done}, 0);
      end
      do_op("post_rst_ld", 3'd1, 8'hC3, 1'b0, 4'd0, 1'b0);

      // randomized operations
      for (int t = 0; t < 200; t++) begin
         ro = 3'($urandom_range(0, 7));
         rd = 8'($urandom);
         if ($urandom_range(0, 5) == 0)
            do_idle("rnd_idle", ro, rd);
         else
            do_op("rnd", ro, rd, 1'($urandom), 4'($urandom), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/acc_shift_reg.md
ACC_SHIFT_REG -- requirements
Module: acc_shift_reg

Interface
Parameters:
REQ-001 The block SHALL have parameter N, default 8, giving the register width in bits (N >= 2).
REQ-002 The block SHALL have parameter AMT_W, default 4, giving the width of the shift-count input.
REQ-003 The block SHALL have parameter ARITH, default 0: 1 = arithmetic right shift (MSB fill), 0 = fill from sin.
Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: operation strobe, sampled only when busy=0.
REQ-007 The block SHALL have port op, input, 3 bits: operation code.
REQ-008 The block SHALL have port in, input, N bits: parallel load data.
REQ-009 The block SHALL have port sin, input, 1 bit: serial fill bit for shift operations.
REQ-010 The block SHALL have port amt, input, AMT_W bits: bit count for shift/rotate operations.
REQ-011 The block SHALL have port out, output, N bits: register contents.
REQ-012 The block SHALL have port cy, output, 1 bit: carry, borrow, or last bit shifted out.
REQ-013 The block SHALL have port zero, output, 1 bit: combinational, 1 when out == 0.
REQ-014 The block SHALL have port busy, output, 1 bit: multi-cycle shift in progress.
REQ-015 The block SHALL have port done, output, 1 bit: registered, one-cycle completion pulse.

Function
REQ-016 Op codes SHALL be: 000 hold, 001 load, 010 clear, 011 inc, 100 dec, 101 shl, 110 shr, 111 rol.
REQ-017 An op SHALL be accepted on a clock edge where en=1 and busy=0; en and op SHALL be ignored while busy=1.
REQ-018 Hold, and en=0 in IDLE, SHALL leave out and cy unchanged, with done=0.
REQ-019 Load SHALL set out=in and cy=0; clear SHALL set out=0 and cy=0; each SHALL pulse done on the following cycle.
REQ-020 Inc SHALL set out=out+1 mod 2^N and cy=carry out (1 only on all-ones to 0); done SHALL pulse.
REQ-021 Dec SHALL set out=out-1 mod 2^N and cy=borrow (1 only on 0 to all-ones); done SHALL pulse.
REQ-022 Each shl step SHALL set cy to the old out[N-1], shift left, and load sin into the LSB.
REQ-023 Each shr step SHALL set cy to the old out[0], shift right, and fill the MSB with old out[N-1] if ARITH=1, else with sin.
REQ-024 Each rol step SHALL set cy to the old out[N-1], rotate left, and ignore sin.
REQ-025 The block SHALL implement a two-state machine with states IDLE and SHIFT.
REQ-026 On acceptance of a shift op with amt=0, out and cy SHALL be unchanged, done SHALL pulse, and the state SHALL remain IDLE.
REQ-027 On acceptance with amt=1, the block SHALL perform one step on the accept edge, pulse done, and remain in IDLE.
REQ-028 On acceptance with amt>1, the block SHALL perform one step on the accept edge, load a remaining-count register with amt-1, set busy=1, and enter SHIFT.
REQ-029 In SHIFT, each edge SHALL perform one step and decrement the remaining count; the edge taking the count from 1 to 0 SHALL return to IDLE, clear busy, and set done=1 for one cycle.
REQ-030 A shift op SHALL take exactly amt edges, with busy high for amt-1 cycles.
REQ-031 sin SHALL be sampled at every step edge, and the latched op SHALL govern all steps.
REQ-032 Values of amt greater than N SHALL be legal: shl/shr keep shifting in fill bits, and rol wraps modulo N.
REQ-033 done SHALL never be high for two consecutive cycles from a single op.
REQ-034 busy and done SHALL never be high in the same cycle.

Reset
REQ-035 While rst=1, the block SHALL immediately force out=0, cy=0, busy=0, done=0, state=IDLE, and remaining count=0, regardless of clk.
REQ-036 Assertion of rst mid-shift SHALL abort the operation with no done pulse, and the first accept after reset release SHALL be a normal op.

Verification
REQ-037 The bench SHALL cover: rst pulsed mid-rol (amt=5), asynchronous to clk -> out=0x00, busy=0, done=0, and no done pulse after release.
REQ-038 The bench SHALL cover: load 0xA5, then shl amt=3 with sin=0 -> busy high for 2 cycles, final out=0x28, cy=1, and exactly one done pulse.
REQ-039 The bench SHALL cover: load 0xFF, then inc -> out=0x00, cy=1, zero=1; then dec -> out=0xFF, cy=1, zero=0.
REQ-040 The bench SHALL cover: load 0x80, then shr amt=2 -> with ARITH=1, out=0xE0 and cy=0; with ARITH=0 and sin=0, out=0x20 and cy=0.
REQ-041 The bench SHALL cover: load 0x5A, then rol amt=8 with en=1 and op=load (in=0xFF) held throughout busy -> busy for 7 cycles, out=0x5A at done, and the load ignored.
REQ-042 The bench SHALL cover: shl amt=0 -> done pulses once, out and cy unchanged, and busy never asserted.
